// File: rtl/mcd212_pkg.sv
// Shared types for the MCD212 RAM arbiter.
// Requester ids, arbiter FSM states and the CPU address swizzle.
package mcd212_pkg;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_CPU  = 2'd1,
        REQ_ICA  = 2'd2,
        REQ_FILE = 2'd3
    } req_id_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // CPU bank bits 18 and 21 land on the top two RAM word-address bits.
    function automatic logic [19:1] ram_map_cpu_addr(
        input logic [22:1] cpu_address
    );
        return {cpu_address[18], cpu_address[21], cpu_address[17:1]};
    endfunction

endpackage

// File: rtl/mcd212_ram_arbiter.sv
// MCD212 single-port RAM arbiter: display file, ICA/DCA and CPU
// share one synchronous-read RAM with a fixed three-cycle access.
module mcd212_ram_arbiter
    import mcd212_pkg::*;
#(
    parameter int MAX_VIDEO_RUN = 4
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         cpu_req,
    input  logic [22:1]  cpu_address,
    input  logic         cpu_write,
    input  logic         cpu_uds,
    input  logic         cpu_lds,
    input  logic [15:0]  cpu_din,
    output logic [15:0]  cpu_dout,
    output logic         cpu_ack,

    input  logic         ica_as,
    input  logic [21:0]  ica_adr,
    output logic [15:0]  ica_din,
    output logic         ica_bus_ack,

    input  logic         file_as,
    input  logic [21:0]  file_adr,
    output logic [15:0]  file_din,
    output logic         file_bus_ack,

    output logic [19:1]  ram_addr,
    output logic [1:0]   ram_we,
    output logic [15:0]  ram_wdata,
    input  logic [15:0]  ram_rdata
);

    localparam int RunW = $clog2(MAX_VIDEO_RUN + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(MAX_VIDEO_RUN);

    state_e          state_q, state_d;
    req_id_e         grant_q, grant_d;
    req_id_e         ack_q, ack_d;
    req_id_e         sel;
    logic [19:1]     addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;
    logic [1:0]      be_q, be_d;
    logic            write_q, write_d;
    logic [RunW-1:0] run_q, run_d;
    logic [15:0]     cpu_dout_q, cpu_dout_d;
    logic [15:0]     ica_din_q, ica_din_d;
    logic [15:0]     file_din_q, file_din_d;
    logic            unused_adr_bits;

    assign unused_adr_bits = ^{ica_adr[21:20], ica_adr[0],
                               file_adr[21:20], file_adr[0]};

    // Video has priority, but a starved CPU wins once the run saturates.
    always_comb begin
        sel = REQ_NONE;
        if (state_q == ST_IDLE) begin
            if (cpu_req && run_q == RunMax) sel = REQ_CPU;
            else if (file_as)               sel = REQ_FILE;
            else if (ica_as)                sel = REQ_ICA;
            else if (cpu_req)               sel = REQ_CPU;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        write_d = write_q;
        run_d   = run_q;
        unique case (state_q)
            ST_IDLE: begin
                if (sel != REQ_NONE) begin
                    state_d = ST_ACCESS;
                    grant_d = sel;
                    wdata_d = cpu_din;
                    write_d = (sel == REQ_CPU) && cpu_write;
                    be_d    = (sel == REQ_CPU) ? {cpu_uds, cpu_lds} : 2'b00;
                    case (sel)
                        REQ_CPU:  addr_d = ram_map_cpu_addr(cpu_address);
                        REQ_ICA:  addr_d = ica_adr[19:1];
                        REQ_FILE: addr_d = file_adr[19:1];
                        default:  addr_d = addr_q;
                    endcase
                end
                if (!cpu_req || sel == REQ_CPU)
                    run_d = '0;
                else if (sel != REQ_NONE && run_q != RunMax)
                    run_d = run_q + 1'b1;
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign ack_d = (state_q == ST_ACCESS) ? grant_q : REQ_NONE;

    assign cpu_ack      = (ack_q == REQ_CPU);
    assign ica_bus_ack  = (ack_q == REQ_ICA);
    assign file_bus_ack = (ack_q == REQ_FILE);

    // Read data is live in the ack cycle, then held until the next completion.
    assign cpu_dout = (cpu_ack && !write_q) ? ram_rdata : cpu_dout_q;
    assign ica_din  = ica_bus_ack ? ram_rdata : ica_din_q;
    assign file_din = file_bus_ack ? ram_rdata : file_din_q;

    assign cpu_dout_d = cpu_dout;
    assign ica_din_d  = ica_din;
    assign file_din_d = file_din;

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = (state_q == ST_ACCESS && write_q) ? be_q : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= REQ_NONE;
            ack_q      <= REQ_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            write_q    <= 1'b0;
            run_q      <= '0;
            cpu_dout_q <= '0;
            ica_din_q  <= '0;
            file_din_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            write_q    <= write_d;
            run_q      <= run_d;
            cpu_dout_q <= cpu_dout_d;
            ica_din_q  <= ica_din_d;
            file_din_q <= file_din_d;
        end
    end

endmodule

// File: tb/tb_mcd212_ram_arbiter.sv
// Directed bench for mcd212_ram_arbiter with a behavioural
// one-cycle synchronous-read RAM attached.
module tb_mcd212_ram_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [22:1] cpu_address;
    logic        cpu_write;
    logic        cpu_uds;
    logic        cpu_lds;
    logic [15:0] cpu_din;
    logic [15:0] cpu_dout;
    logic        cpu_ack;
    logic        ica_as;
    logic [21:0] ica_adr;
    logic [15:0] ica_din;
    logic        ica_bus_ack;
    logic        file_as;
    logic [21:0] file_adr;
    logic [15:0] file_din;
    logic        file_bus_ack;
    logic [19:1] ram_addr;
    logic [1:0]  ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    logic [15:0] mem [0:(1<<19)-1];
    logic        pl_en;
    logic [19:1] pl_addr;
    logic [15:0] pl_data;
    logic [2:0]  acks;

    int n_cmp = 0;
    int n_err = 0;

    mcd212_ram_arbiter #(.MAX_VIDEO_RUN(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_address  (cpu_address),
        .cpu_write    (cpu_write),
        .cpu_uds      (cpu_uds),
        .cpu_lds      (cpu_lds),
        .cpu_din      (cpu_din),
        .cpu_dout     (cpu_dout),
        .cpu_ack      (cpu_ack),
        .ica_as       (ica_as),
        .ica_adr      (ica_adr),
        .ica_din      (ica_din),
        .ica_bus_ack  (ica_bus_ack),
        .file_as      (file_as),
        .file_adr     (file_adr),
        .file_din     (file_din),
        .file_bus_ack (file_bus_ack),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    assign acks = {cpu_ack, ica_bus_ack, file_bus_ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else begin
            if (ram_we[1]) mem[ram_addr][15:8] <= ram_wdata[15:8];
            if (ram_we[0]) mem[ram_addr][7:0]  <= ram_wdata[7:0];
        end
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic [1:0]  who;
        logic [22:0] byte_a;
        logic [21:0] vadr;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] din;
        logic        pl;
        logic [15:0] pl_d;
        logic [19:1] exp_ra;
        logic [1:0]  exp_we;
        logic [15:0] exp_out;
        logic [15:0] exp_mem;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [19:1] a, input logic [15:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        tick();
        pl_en   = 1'b0;
    endtask

    function automatic logic [15:0] dout_of(input logic [1:0] w);
        case (w)
            2'd0:    return cpu_dout;
            2'd1:    return ica_din;
            default: return file_din;
        endcase
    endfunction

    task automatic run_vec(input int i, input vec_t v);
        case (v.who)
            2'd0: begin
                cpu_address = v.byte_a[22:1];
                cpu_write   = v.wr;
                cpu_uds     = v.be[1];
                cpu_lds     = v.be[0];
                cpu_din     = v.din;
                cpu_req     = 1'b1;
            end
            2'd1: begin
                ica_adr = v.vadr;
                ica_as  = 1'b1;
            end
            default: begin
                file_adr = v.vadr;
                file_as  = 1'b1;
            end
        endcase
        tick();
        chk($sformatf("v%0d access ram_addr", i), 32'(ram_addr), 32'(v.exp_ra));
        chk($sformatf("v%0d access ram_we", i), 32'(ram_we), 32'(v.exp_we));
        chk($sformatf("v%0d access acks", i), 32'(acks), 32'd0);
        if (v.wr)
            chk($sformatf("v%0d wdata", i), 32'(ram_wdata), 32'(v.din));
        tick();
        chk($sformatf("v%0d done acks", i), 32'(acks), 32'(3'b100 >> v.who));
        chk($sformatf("v%0d done ram_we", i), 32'(ram_we), 32'd0);
        chk($sformatf("v%0d done data", i), 32'(dout_of(v.who)),
            32'(v.exp_out));
        cpu_req = 1'b0;
        ica_as  = 1'b0;
        file_as = 1'b0;
        tick();
        chk($sformatf("v%0d idle acks", i), 32'(acks), 32'd0);
        chk($sformatf("v%0d held data", i), 32'(dout_of(v.who)),
            32'(v.exp_out));
        chk($sformatf("v%0d ram word", i), 32'(mem[v.exp_ra]),
            32'(v.exp_mem));
    endtask

    initial begin : main
        int kf, ki, kc, fb, fa;
        logic cpu_seen;

        reset = 1'b0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        cpu_req = 0; cpu_address = '0; cpu_write = 0;
        cpu_uds = 0; cpu_lds = 0; cpu_din = '0;
        ica_as = 0; ica_adr = '0;
        file_as = 0; file_adr = '0;

        vecs[0] = '{2'd0, 23'h000100, 22'h0, 1'b0, 2'b11, 16'h0000,
                    1'b1, 16'h1234, 19'h00080, 2'b00, 16'h1234, 16'h1234};
        vecs[1] = '{2'd0, 23'h040000, 22'h0, 1'b1, 2'b10, 16'hAB00,
                    1'b1, 16'h5566, 19'h40000, 2'b10, 16'h1234, 16'hAB66};
        vecs[2] = '{2'd0, 23'h200246, 22'h0, 1'b1, 2'b01, 16'h00CD,
                    1'b1, 16'h7788, 19'h20123, 2'b01, 16'h1234, 16'h77CD};
        vecs[3] = '{2'd0, 23'h7FFFFE, 22'h0, 1'b1, 2'b11, 16'hBEEF,
                    1'b1, 16'h0000, 19'h7FFFF, 2'b11, 16'h1234, 16'hBEEF};
        vecs[4] = '{2'd1, 23'h0, 22'h3ABCDE, 1'b0, 2'b00, 16'h0,
                    1'b1, 16'hCAFE, 19'h55E6F, 2'b00, 16'hCAFE, 16'hCAFE};
        vecs[5] = '{2'd2, 23'h0, 22'h000002, 1'b0, 2'b00, 16'h0,
                    1'b1, 16'h0F0F, 19'h00001, 2'b00, 16'h0F0F, 16'h0F0F};
        vecs[6] = '{2'd0, 23'h040000, 22'h0, 1'b0, 2'b11, 16'h0,
                    1'b0, 16'h0000, 19'h40000, 2'b00, 16'hAB66, 16'hAB66};
        vecs[7] = '{2'd1, 23'h0, 22'h0FFFFE, 1'b0, 2'b00, 16'h0,
                    1'b0, 16'h0000, 19'h7FFFF, 2'b00, 16'hBEEF, 16'hBEEF};
        vecs[8] = '{2'd2, 23'h0, 22'h100000, 1'b0, 2'b00, 16'h0,
                    1'b1, 16'h4242, 19'h00000, 2'b00, 16'h4242, 16'h4242};

        foreach (vecs[i]) if (vecs[i].pl) preload(vecs[i].exp_ra, vecs[i].pl_d);
        preload(19'h00008, 16'hA001);
        preload(19'h00010, 16'hA002);
        preload(19'h00020, 16'hA003);
        preload(19'h00123, 16'h1111);

        chk("rst ram_addr", 32'(ram_addr), 32'd0);
        chk("rst ram_we", 32'(ram_we), 32'd0);
        chk("rst ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst acks", 32'(acks), 32'd0);
        chk("rst cpu_dout", 32'(cpu_dout), 32'd0);
        chk("rst ica_din", 32'(ica_din), 32'd0);
        chk("rst file_din", 32'(file_din), 32'd0);

        reset = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Simultaneous requests: file, then ica, then cpu.
        kf = -1; ki = -1; kc = -1;
        file_adr = 22'h000010; file_as = 1'b1;
        ica_adr  = 22'h000020; ica_as  = 1'b1;
        cpu_address = 22'h000020; cpu_write = 1'b0;
        cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (file_bus_ack) begin
                kf = k; file_as = 1'b0;
                chk("prio file_din", 32'(file_din), 32'h0000A001);
            end
            if (ica_bus_ack) begin
                ki = k; ica_as = 1'b0;
                chk("prio ica_din", 32'(ica_din), 32'h0000A002);
            end
            if (cpu_ack) begin
                kc = k; cpu_req = 1'b0;
                chk("prio cpu_dout", 32'(cpu_dout), 32'h0000A003);
            end
        end
        chk("prio file ack cycle", 32'(kf), 32'd2);
        chk("prio ica ack cycle", 32'(ki), 32'd5);
        chk("prio cpu ack cycle", 32'(kc), 32'd8);

        // Continuous file stream against a waiting CPU.
        fb = 0; fa = 0; kc = -1; cpu_seen = 1'b0;
        file_adr = 22'h000010; file_as = 1'b1;
        cpu_address = 22'h000020; cpu_req = 1'b1;
        for (int k = 1; k <= 40 && fa < 2; k++) begin
            tick();
            if (file_bus_ack) begin
                if (cpu_seen) fa++;
                else fb++;
                if (fa == 2) file_as = 1'b0;
            end
            if (cpu_ack) begin
                cpu_seen = 1'b1; kc = k; cpu_req = 1'b0;
            end
        end
        file_as = 1'b0;
        cpu_req = 1'b0;
        tick();
        chk("run file acks before cpu", 32'(fb), 32'd4);
        chk("run cpu ack cycle", 32'(kc), 32'd14);
        chk("run file acks after cpu", 32'(fa), 32'd2);

        // Reset landing in the ACCESS cycle of a CPU write.
        cpu_address = 22'h000123; cpu_write = 1'b1;
        cpu_uds = 1'b1; cpu_lds = 1'b1; cpu_din = 16'hFFFF; cpu_req = 1'b1;
        tick();
        chk("abort pre we", 32'(ram_we), 32'd3);
        reset = 1'b0;
        cpu_req = 1'b0; cpu_write = 1'b0;
        ica_adr = 22'h000020; ica_as = 1'b1;
        #1;
        chk("abort ram_we", 32'(ram_we), 32'd0);
        chk("abort ram_addr", 32'(ram_addr), 32'd0);
        chk("abort ram_wdata", 32'(ram_wdata), 32'd0);
        chk("abort acks", 32'(acks), 32'd0);
        chk("abort cpu_dout", 32'(cpu_dout), 32'd0);
        chk("abort ica_din", 32'(ica_din), 32'd0);
        chk("abort file_din", 32'(file_din), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("abort held acks", 32'(acks), 32'd0);
        end
        reset = 1'b1;
        tick();
        chk("release grant addr", 32'(ram_addr), 32'h10);
        chk("release acks", 32'(acks), 32'd0);
        tick();
        chk("release ica ack", 32'(acks), 32'b010);
        chk("release ica_din", 32'(ica_din), 32'h0000A002);
        ica_as = 1'b0;
        tick();
        chk("abort ram untouched", 32'(mem[19'h00123]), 32'h00001111);

        // Requester drops ica_as while its access is under way.
        ica_adr = 22'h3ABCDE; ica_as = 1'b1;
        tick();
        ica_as = 1'b0;
        chk("drop access acks", 32'(acks), 32'd0);
        tick();
        chk("drop ica ack", 32'(acks), 32'b010);
        chk("drop ica_din", 32'(ica_din), 32'h0000CAFE);
        tick();
        chk("drop ack cleared", 32'(acks), 32'd0);
        tick();
        chk("drop no second ack", 32'(acks), 32'd0);
        chk("drop data held", 32'(ica_din), 32'h0000CAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
